// File: rtl/sseg_load_if.sv
// Load port of the 7-segment scan controller: a packed BCD word offered
// with a valid/ready handshake.
interface sseg_load_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic                    load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank, with a
// blanking gap per digit and a double-buffered value that updates only on frame
// boundaries.
// Optional leading-zero blanking is compiled in with `define SSEG_LZB_EN.
module sseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_i,
    sseg_load_if.slave                    load_if,
    output logic [3:0]                    bcd_out_o,
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
    output logic                          frame_done_o
);

    localparam int DIG_W   = $clog2(NUM_DIGITS);
    localparam int DATA_W  = 4 * NUM_DIGITS;
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [DIG_W-1:0] DIG_ONE    = DIG_W'(1);
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic [DATA_W-1:0]       active_q, active_d;
    logic [DATA_W-1:0]       pending_q, pending_d;
    logic                    pend_full_q, pend_full_d;
    logic                    ready_q, ready_d;
    logic                    frame_done_q, frame_done_d;
    logic [3:0]              bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    xfer;
    logic                    frame_end;
    logic                    promote;
    logic [3:0]              nibble_d;
    logic [NUM_DIGITS-1:0]   lz_dark;

    // ready_q mirrors an empty pending buffer, so a transfer and a promotion
    // can never coincide.
    assign xfer      = load_if.load_valid & ready_q;
    assign frame_end = (state_q == ST_DRIVE) && (cnt_q == '0) && (digit_q == LAST_DIGIT);
    assign promote   = pend_full_q && ((state_q == ST_IDLE) || frame_end);

    // Scan sequencing: one down-counter times both the gap and the dwell.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digit_d      = digit_q;
        frame_done_d = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            digit_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    digit_d = '0;
                    if (HAS_BLANK) begin
                        state_d = ST_BLANK;
                        cnt_d   = BLANK_LOAD;
                    end else begin
                        state_d = ST_DRIVE;
                        cnt_d   = DWELL_LOAD;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DRIVE;
                        cnt_d   = DWELL_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == '0) begin
                        frame_done_d = (digit_q == LAST_DIGIT);
                        digit_d      = (digit_q == LAST_DIGIT) ? '0 : digit_q + DIG_ONE;
                        if (HAS_BLANK) begin
                            state_d = ST_BLANK;
                            cnt_d   = BLANK_LOAD;
                        end else begin
                            state_d = ST_DRIVE;
                            cnt_d   = DWELL_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    digit_d = '0;
                end
            endcase
        end
    end

    // Double buffer: pending is promoted at a frame boundary or whenever idle.
    always_comb begin
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        if (promote) begin
            active_d    = pending_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pending_d   = load_if.load_data;
            pend_full_d = 1'b1;
        end
        ready_d = !pend_full_d;
    end

    // Outputs are derived from next-state values so the registered pins line
    // up with the state they describe.
    assign nibble_d = active_d[{digit_d, 2'b00} +: 4];
    assign bcd_d    = (state_d == ST_IDLE) ? 4'h0 : nibble_d;

`ifdef SSEG_LZB_EN
    assign lz_dark[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lzb
        assign lz_dark[gi] = (active_d[DATA_W-1:4*gi] == '0);
    end
`else
    assign lz_dark = '0;
`endif

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
        assign an_d[gi] = !((state_d == ST_DRIVE) && (digit_d == DIG_W'(gi)) && !lz_dark[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            digit_q      <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_full_q  <= 1'b0;
            ready_q      <= 1'b1;
            frame_done_q <= 1'b0;
            bcd_q        <= 4'h0;
            an_q         <= '1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_full_q  <= pend_full_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
            bcd_q        <= bcd_d;
            an_q         <= an_d;
        end
    end

    assign load_if.load_ready = ready_q;
    assign bcd_out_o          = bcd_q;
    assign an_o               = an_q;
    assign digit_idx_o        = digit_q;
    assign frame_done_o       = frame_done_q;

endmodule
